// File: rtl/nonce_search_pkg.sv
// Shared types and constants for the nonce search controller.
// Optional CONTINUE_SEARCH_EN build is handled in nonce_search_ctrl.
package nonce_search_pkg;

  localparam int unsigned HASH_W   = 256;
  localparam int unsigned SEED_W   = 224;
  localparam int unsigned DIFF_W   = 9;
  localparam int unsigned MAX_DIFF = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_REPORT,
    S_DONE
  } state_e;

  // A digest has at most 256 leading zeros, so larger requests saturate there.
  function automatic logic [DIFF_W-1:0] clamp_diff(input logic [DIFF_W-1:0] d);
    return (d > DIFF_W'(MAX_DIFF)) ? DIFF_W'(MAX_DIFF) : d;
  endfunction

endpackage

// File: rtl/digest_difficulty_cmp.sv
// Leading-zero count of a digest compared against a (pre-clamped) difficulty.
module digest_difficulty_cmp
  import nonce_search_pkg::*;
(
  input  logic [HASH_W-1:0] digest,
  input  logic [DIFF_W-1:0] difficulty,
  output logic              match_c
);

  logic [DIFF_W-1:0] lzc;
  logic              seen;

  // Scan from the MSB; the first set bit fixes the count, all-zero gives HASH_W.
  always_comb begin
    lzc  = DIFF_W'(HASH_W);
    seen = 1'b0;
    for (int i = int'(HASH_W) - 1; i >= 0; i--) begin
      if (!seen && digest[i]) begin
        lzc  = DIFF_W'(int'(HASH_W) - 1 - i);
        seen = 1'b1;
      end
    end
  end

  assign match_c = (lzc >= difficulty);

endmodule

// File: rtl/nonce_search_ctrl.sv
// Feeds {seed, counter} nonces to a fixed-latency hash pipeline and reports the first
// digest meeting the difficulty. Define CONTINUE_SEARCH_EN to keep searching after a report.
module nonce_search_ctrl
  import nonce_search_pkg::*;
#(
  parameter int unsigned HASH_LATENCY = 64,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [SEED_W-1:0] seed,
  input  logic [CNT_W-1:0]  start_nonce,
  input  logic [CNT_W-1:0]  max_count,
  input  logic [DIFF_W-1:0] difficulty,
  output logic [HASH_W-1:0] hash_in,
  input  logic [HASH_W-1:0] hash_out,
  output logic              busy,
  output logic              found_valid,
  input  logic              found_ready,
  output logic [HASH_W-1:0] found_nonce,
  output logic [HASH_W-1:0] found_digest,
  output logic [CNT_W-1:0]  attempts,
  output logic              done,
  output logic              exhausted
);

  localparam int unsigned WAIT_W = (HASH_LATENCY > 1) ? $clog2(HASH_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(HASH_LATENCY - 1);

  state_e              state_q, state_d;
  logic [SEED_W-1:0]   seed_q, seed_d;
  logic [CNT_W-1:0]    nonce_q, nonce_d;
  logic [CNT_W-1:0]    max_q, max_d;
  logic [DIFF_W-1:0]   diff_q, diff_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    attempts_q, attempts_d;
  logic                exhausted_q, exhausted_d;
  logic [HASH_W-1:0]   found_nonce_q, found_nonce_d;
  logic [HASH_W-1:0]   found_digest_q, found_digest_d;
  logic                found_valid_q, found_valid_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    attempts_inc;
  logic                match_c;

  digest_difficulty_cmp u_cmp (
    .digest     (hash_out),
    .difficulty (diff_q),
    .match_c    (match_c)
  );

  always_comb begin
    state_d        = state_q;
    seed_d         = seed_q;
    nonce_d        = nonce_q;
    max_d          = max_q;
    diff_d         = diff_q;
    wait_d         = wait_q;
    attempts_d     = attempts_q;
    exhausted_d    = exhausted_q;
    found_nonce_d  = found_nonce_q;
    found_digest_d = found_digest_q;
    attempts_inc   = attempts_q + CNT_W'(1);

    // Abort wins over everything else and leaves the result registers untouched.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            seed_d      = seed;
            nonce_d     = start_nonce;
            max_d       = max_count;
            diff_d      = clamp_diff(difficulty);
            attempts_d  = '0;
            exhausted_d = 1'b0;
            wait_d      = '0;
            state_d     = S_WAIT;
          end
        end
        S_WAIT: begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q == WAIT_LAST) begin
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          attempts_d = attempts_inc;
          // A budget of 0 means 2^CNT_W: the incremented count wraps to 0 and matches.
          if (match_c) begin
            found_nonce_d  = hash_in;
            found_digest_d = hash_out;
            state_d        = S_REPORT;
          end else if (attempts_inc == max_q) begin
            exhausted_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            nonce_d = nonce_q + CNT_W'(1);
            wait_d  = '0;
            state_d = S_WAIT;
          end
        end
        S_REPORT: begin
          if (found_ready) begin
`ifdef CONTINUE_SEARCH_EN
            if (attempts_q == max_q) begin
              exhausted_d = 1'b1;
              state_d     = S_DONE;
            end else begin
              nonce_d = nonce_q + CNT_W'(1);
              wait_d  = '0;
              state_d = S_WAIT;
            end
`else
            state_d = S_DONE;
`endif
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    found_valid_d = (state_d == S_REPORT);
    done_d        = (state_d == S_DONE);
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      seed_q         <= '0;
      nonce_q        <= '0;
      max_q          <= '0;
      diff_q         <= '0;
      wait_q         <= '0;
      attempts_q     <= '0;
      exhausted_q    <= 1'b0;
      found_nonce_q  <= '0;
      found_digest_q <= '0;
      found_valid_q  <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      seed_q         <= seed_d;
      nonce_q        <= nonce_d;
      max_q          <= max_d;
      diff_q         <= diff_d;
      wait_q         <= wait_d;
      attempts_q     <= attempts_d;
      exhausted_q    <= exhausted_d;
      found_nonce_q  <= found_nonce_d;
      found_digest_q <= found_digest_d;
      found_valid_q  <= found_valid_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
    end
  end

  assign hash_in      = {seed_q, nonce_q};
  assign busy         = busy_q;
  assign found_valid  = found_valid_q;
  assign found_nonce  = found_nonce_q;
  assign found_digest = found_digest_q;
  assign attempts     = attempts_q;
  assign done         = done_q;
  assign exhausted    = exhausted_q;

endmodule

// File: doc/nonce_search_ctrl.md
Name: nonce_search_ctrl

Overview:
- Drives the 256-bit SHA-256 nonce-hash pipeline from its input side and consumes its digest at the output end.
- Builds each candidate nonce as {seed, counter} and holds it stable for the pipeline latency.
- Samples the digest, tests it against a leading-zero difficulty, and reports the first matching nonce and digest over a valid/ready handshake.
- Sits between the host/control logic and one hash pipeline instance.

Parameters:
- HASH_LATENCY, 64, cycles from a hash_in change to a valid hash_out; must be ≥1.
- CNT_W, 32, width of the nonce counter, max_count and attempts.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a search when idle.
- abort  in  1  synchronous; cancels a search.
- seed  in  224  upper nonce bits, latched on start.
- start_nonce  in  32  first counter value, latched on start.
- max_count  in  32  attempt budget; 0 means 2^32 attempts.
- difficulty  in  9  required leading zero bits of the digest; values above 256 clamp to 256.
- hash_in  out  256  to pipeline input; equals {seed_q, nonce_q}.
- hash_out  in  256  pipeline digest.
- busy  out  1  high in every state except IDLE.
- found_valid  out  1  match available.
- found_ready  in  1  consumer accepts the match.
- found_nonce  out  256  matching nonce.
- found_digest  out  256  matching digest.
- attempts  out  32  digests checked in the current search.
- done  out  1  one-cycle pulse at search end.
- exhausted  out  1  sticky; budget used up with no match; cleared on start.

Behaviour:
- Reset: all outputs and registers are 0; state is IDLE. Reset acts immediately, including mid-search.
- States: IDLE, WAIT, CHECK, REPORT, DONE.
- IDLE: start latches seed, start_nonce, max_count and difficulty (clamped), clears attempts, exhausted and wait_cnt, then goes to WAIT. hash_in changes on that same edge.
- WAIT: wait_cnt increments each cycle. When wait_cnt == HASH_LATENCY-1, go to CHECK. hash_in is held constant throughout WAIT.
- CHECK: hash_out is treated as valid. attempts increments (wraps at 2^32).
  - Match means the digest's leading zero count ≥ difficulty. Difficulty 0 always matches.
  - On match: load found_nonce = hash_in and found_digest = hash_out, then go to REPORT.
  - Otherwise, if attempts_new == max_count (with max_count = 0 meaning attempts_new wraps to 0): set exhausted and go to DONE.
  - Otherwise: nonce_q increments mod 2^32 (0xFFFFFFFF → 0), seed is unchanged, wait_cnt clears, and the FSM returns to WAIT.
- Cost per attempt: HASH_LATENCY+1 cycles.
- REPORT: found_valid is high; found_* and hash_in stay stable until found_ready. On the handshake edge found_valid drops and the FSM goes to DONE (default build). found_ready is ignored outside REPORT.
- DONE: done is high for exactly one cycle, then the FSM returns to IDLE. found_nonce, found_digest and attempts keep their values until the next start.
- start while busy is ignored.
- abort in any non-IDLE state → IDLE on the next edge.
  - Drops found_valid, does not pulse done, and leaves exhausted unchanged.
  - abort has priority over start and found_ready in the same cycle.
- Exhaustion and match on the same attempt: the match wins (REPORT); exhausted stays 0.

Optional Feature:
- Macro: CONTINUE_SEARCH_EN.
- Defined: after the REPORT handshake, nonce_q increments and the FSM re-enters WAIT if budget remains; otherwise it goes to DONE with exhausted=1. done pulses only at budget end or when the final attempt is reported.
- Undefined: the search stops at the first match as described above.

Decomposition:
- Package nonce_search_pkg:
  - state enum
  - HASH_W=256, SEED_W=224, DIFF_W=9
  - MAX_DIFF=256
- One sub-module, digest_difficulty_cmp: combinational leading-zero count of a 256-bit digest, compared against a clamped difficulty, with a match output.

Test Plan:
- Real pipeline, difficulty=0, start_nonce=5, max_count=10 → found_valid exactly 65 cycles after start; found_nonce[31:0]=5; attempts=1; done pulses after found_ready.
- Stub digest (0 when hash_in[31:0]==7, else all-ones), start_nonce=4, difficulty=20 → hash_in low sequence 4,5,6,7; found_nonce[31:0]=7; attempts=4; found_digest=0.
- Stub all-ones, start_nonce=0xFFFFFFFE, max_count=4, difficulty=1 → hash_in low sequence FFFFFFFE, FFFFFFFF, 0, 1; exhausted=1; done at cycle 4×65; found_valid never high.
- Match then found_ready held low for 10 cycles → found_valid, found_nonce and hash_in stable; no extra attempts; done one cycle after ready.
- rst asserted at cycle 30 of WAIT → all outputs 0 immediately. abort mid-WAIT → busy=0 next cycle, done=0. start while busy → no effect.
- CONTINUE_SEARCH_EN, stub matching nonces 2 and 3, start_nonce=0, max_count=5 → two REPORT handshakes (nonces 2, 3), then exhausted=1, attempts=5, single done.
